// File: rtl/eu_operand_cache.sv
// Per-execution-unit operand cache: NUM_REG single-slot entries written by the icon or the local ALPU and freed by explicit consume.
// Optional macro EU_OPERAND_CACHE_WR_BYPASS_EN forwards same-cycle accepted write data to readers of a free entry.
module eu_operand_cache #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_REG      = 16,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned LOG2_NUM_REG = $clog2(NUM_REG)
) (
  input  logic                                 i_clk,
  input  logic                                 reset,
  input  logic                                 i_icon_wr_valid,
  input  logic [LOG2_NUM_REG-1:0]              i_icon_wr_addr,
  input  logic [DATA_WIDTH-1:0]                i_icon_wr_data,
  output logic                                 o_icon_wr_ready,
  input  logic                                 i_loc_wr_valid,
  input  logic [LOG2_NUM_REG-1:0]              i_loc_wr_addr,
  input  logic [DATA_WIDTH-1:0]                i_loc_wr_data,
  output logic                                 o_loc_wr_ready,
  input  logic [NUM_RD_PORTS-1:0]              i_rd_valid,
  input  logic [NUM_RD_PORTS*LOG2_NUM_REG-1:0] i_rd_addr,
  input  logic [NUM_RD_PORTS-1:0]              i_rd_consume,
  output logic [NUM_RD_PORTS-1:0]              o_rd_hit,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   o_rd_data,
  output logic [$clog2(NUM_REG+1)-1:0]         o_num_full
);

  localparam int unsigned CNT_W = $clog2(NUM_REG + 1);

  // Handshake: ready depends only on registered state and the competing local
  // request, never on its own valid; a write commits on the edge where valid && ready.
  logic [DATA_WIDTH-1:0] r_data [NUM_REG];
  logic [NUM_REG-1:0]    r_full;
  logic [CNT_W-1:0]      r_num_full;

  logic                  w_loc_acc;
  logic                  w_icon_acc;
  logic [NUM_REG-1:0]    w_wr_en;
  logic [DATA_WIDTH-1:0] w_wr_data [NUM_REG];
  logic [NUM_REG-1:0]    w_cons;
  logic [NUM_REG-1:0]    w_full_next;
  logic [CNT_W-1:0]      w_cnt_next;

  assign o_loc_wr_ready  = ~r_full[i_loc_wr_addr];
  assign o_icon_wr_ready = ~r_full[i_icon_wr_addr] &
                           ~(i_loc_wr_valid & (i_loc_wr_addr == i_icon_wr_addr));
  assign w_loc_acc       = i_loc_wr_valid & o_loc_wr_ready;
  assign w_icon_acc      = i_icon_wr_valid & o_icon_wr_ready;
  assign o_num_full      = r_num_full;

  // Local and icon can never both be accepted for the same entry.
  always_comb begin
    for (int i = 0; i < NUM_REG; i++) begin
      w_wr_en[i]   = (w_loc_acc  && (i_loc_wr_addr  == LOG2_NUM_REG'(i))) ||
                     (w_icon_acc && (i_icon_wr_addr == LOG2_NUM_REG'(i)));
      w_wr_data[i] = (w_loc_acc && (i_loc_wr_addr == LOG2_NUM_REG'(i))) ?
                     i_loc_wr_data : i_icon_wr_data;
    end
  end

  always_comb begin
    logic [LOG2_NUM_REG-1:0] w_a;
    o_rd_hit  = '0;
    o_rd_data = '0;
    w_cons    = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      w_a = i_rd_addr[p*LOG2_NUM_REG +: LOG2_NUM_REG];
`ifdef EU_OPERAND_CACHE_WR_BYPASS_EN
      o_rd_hit[p] = i_rd_valid[p] & (r_full[w_a] | w_wr_en[w_a]);
      if (o_rd_hit[p])
        o_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = r_full[w_a] ? r_data[w_a] : w_wr_data[w_a];
`else
      o_rd_hit[p] = i_rd_valid[p] & r_full[w_a];
      if (o_rd_hit[p])
        o_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = r_data[w_a];
`endif
      if (i_rd_consume[p] && o_rd_hit[p])
        w_cons[w_a] = 1'b1;
    end
  end

  // A consumed bypass write leaves the entry free, so consume overrides the write.
  assign w_full_next = (r_full | w_wr_en) & ~w_cons;

  always_comb begin
    w_cnt_next = '0;
    for (int i = 0; i < NUM_REG; i++)
      w_cnt_next = w_cnt_next + CNT_W'(w_full_next[i]);
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_full     <= '0;
      r_num_full <= '0;
      for (int i = 0; i < NUM_REG; i++)
        r_data[i] <= '0;
    end else begin
      r_full     <= w_full_next;
      r_num_full <= w_cnt_next;
      for (int i = 0; i < NUM_REG; i++)
        if (w_wr_en[i])
          r_data[i] <= w_wr_data[i];
    end
  end

endmodule

// File: tb/tb_eu_operand_cache.sv
// Bench for eu_operand_cache: directed scenarios plus random traffic checked against a per-entry queue model.
module tb_eu_operand_cache;

  localparam int DW  = 16;
  localparam int NR  = 16;
  localparam int NP  = 2;
  localparam int AW  = 4;
  localparam int CW  = 5;
`ifdef EU_OPERAND_CACHE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              reset;
  logic              i_icon_wr_valid, i_loc_wr_valid;
  logic [AW-1:0]     i_icon_wr_addr, i_loc_wr_addr;
  logic [DW-1:0]     i_icon_wr_data, i_loc_wr_data;
  logic              o_icon_wr_ready, o_loc_wr_ready;
  logic [NP-1:0]     i_rd_valid, i_rd_consume, o_rd_hit;
  logic [NP*AW-1:0]  i_rd_addr;
  logic [NP*DW-1:0]  o_rd_data;
  logic [CW-1:0]     o_num_full;

  eu_operand_cache dut (
    .i_clk(i_clk), .reset(reset),
    .i_icon_wr_valid(i_icon_wr_valid), .i_icon_wr_addr(i_icon_wr_addr),
    .i_icon_wr_data(i_icon_wr_data), .o_icon_wr_ready(o_icon_wr_ready),
    .i_loc_wr_valid(i_loc_wr_valid), .i_loc_wr_addr(i_loc_wr_addr),
    .i_loc_wr_data(i_loc_wr_data), .o_loc_wr_ready(o_loc_wr_ready),
    .i_rd_valid(i_rd_valid), .i_rd_addr(i_rd_addr), .i_rd_consume(i_rd_consume),
    .o_rd_hit(o_rd_hit), .o_rd_data(o_rd_data), .o_num_full(o_num_full)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard ----------------
  // Each entry holds at most one unread operand: empty queue means FREE.
  logic [DW-1:0] exp_q [NR][$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) exp_q[i].delete();
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; drives one cycle, checks, updates the model at the rising edge.
  task automatic do_cycle(input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                          input logic iv, input logic [AW-1:0] ia, input logic [DW-1:0] id,
                          input logic [NP-1:0] rv, input logic [AW-1:0] ra0,
                          input logic [AW-1:0] ra1, input logic [NP-1:0] rc);
    logic          e_lrdy, e_irdy, l_acc, i_acc;
    logic [NP-1:0] e_hit;
    logic [DW-1:0] e_data [NP];
    logic [AW-1:0] ra [NP];
    bit            consumed [NR];
    int            e_num;
    i_loc_wr_valid = lv;  i_loc_wr_addr = la;  i_loc_wr_data = ld;
    i_icon_wr_valid = iv; i_icon_wr_addr = ia; i_icon_wr_data = id;
    i_rd_valid = rv; i_rd_addr = {ra1, ra0}; i_rd_consume = rc;
    ra[0] = ra0; ra[1] = ra1;
    #1;
    e_lrdy = (exp_q[la].size() == 0);
    e_irdy = (exp_q[ia].size() == 0) && !(lv && la == ia);
    l_acc  = lv && e_lrdy;
    i_acc  = iv && e_irdy;
    e_num  = 0;
    for (int i = 0; i < NR; i++) begin
      e_num += exp_q[i].size();
      consumed[i] = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      e_data[p] = '0;
      e_hit[p]  = 1'b0;
      if (rv[p]) begin
        if (exp_q[ra[p]].size() != 0) begin
          e_hit[p] = 1'b1; e_data[p] = exp_q[ra[p]][0];
        end else if (BYP && l_acc && la == ra[p]) begin
          e_hit[p] = 1'b1; e_data[p] = ld;
        end else if (BYP && i_acc && ia == ra[p]) begin
          e_hit[p] = 1'b1; e_data[p] = id;
        end
      end
      if (e_hit[p] && rc[p]) consumed[ra[p]] = 1'b1;
    end
    check_val("loc_ready", {31'b0, o_loc_wr_ready}, {31'b0, e_lrdy});
    check_val("icon_ready", {31'b0, o_icon_wr_ready}, {31'b0, e_irdy});
    check_val("num_full", {27'b0, o_num_full}, e_num);
    for (int p = 0; p < NP; p++) begin
      check_val($sformatf("rd_hit%0d", p), {31'b0, o_rd_hit[p]}, {31'b0, e_hit[p]});
      check_val($sformatf("rd_data%0d", p), {16'b0, o_rd_data[p*DW +: DW]}, {16'b0, e_data[p]});
    end
    @(posedge i_clk);
    for (int i = 0; i < NR; i++)
      if (consumed[i] && exp_q[i].size() != 0) void'(exp_q[i].pop_front());
    if (l_acc && !consumed[la]) exp_q[la].push_back(ld);
    if (i_acc && !consumed[ia]) exp_q[ia].push_back(id);
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_loc_wr_valid = 0; i_loc_wr_addr = 0; i_loc_wr_data = 0;
    i_icon_wr_valid = 0; i_icon_wr_addr = 0; i_icon_wr_data = 0;
    i_rd_valid = 0; i_rd_addr = 0; i_rd_consume = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    clear_model();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    idle_inputs();
    @(negedge i_clk);
    apply_reset();
    // reset state: all free, no hits, both readies high
    do_cycle(0, 4'd3, 16'h0, 0, 4'd5, 16'h0, 2'b11, 4'd3, 4'd5, 2'b00);

    // local write then zero-latency read
    do_cycle(1, 4'd3, 16'h1234, 0, 4'd0, 16'h0, 2'b01, 4'd3, 4'd0, 2'b00);
    do_cycle(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 2'b01, 4'd3, 4'd0, 2'b00);

    // icon stalls on full entry 3, consume at N keeps ready low, accepted at N+1
    do_cycle(0, 4'd0, 16'h0, 1, 4'd3, 16'hBEEF, 2'b00, 4'd0, 4'd0, 2'b00);
    do_cycle(0, 4'd0, 16'h0, 1, 4'd3, 16'hBEEF, 2'b10, 4'd0, 4'd3, 2'b10);
    do_cycle(0, 4'd0, 16'h0, 1, 4'd3, 16'hBEEF, 2'b00, 4'd0, 4'd0, 2'b00);
    do_cycle(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 2'b01, 4'd3, 4'd0, 2'b01);

    // same-entry collision: local wins
    do_cycle(1, 4'd5, 16'h0001, 1, 4'd5, 16'h0002, 2'b00, 4'd0, 4'd0, 2'b00);
    do_cycle(0, 4'd0, 16'h0, 1, 4'd5, 16'h0002, 2'b01, 4'd5, 4'd0, 2'b01);
    do_cycle(0, 4'd0, 16'h0, 1, 4'd5, 16'h0002, 2'b00, 4'd0, 4'd0, 2'b00);
    do_cycle(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 2'b01, 4'd5, 4'd0, 2'b01);

    // both ports consume entry 7 together: freed once
    do_cycle(1, 4'd7, 16'hCAFE, 0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0, 2'b00);
    do_cycle(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 2'b11, 4'd7, 4'd7, 2'b11);
    do_cycle(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 2'b11, 4'd7, 4'd7, 2'b00);

    // write + read/consume of the same free entry in one cycle
    do_cycle(1, 4'd9, 16'h00AA, 0, 4'd0, 16'h0, 2'b01, 4'd9, 4'd0, 2'b01);
    do_cycle(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 2'b01, 4'd9, 4'd0, 2'b01);

    // fill every entry, then free two and refill while consuming a third
    for (int i = 0; i < NR; i++)
      do_cycle(1, AW'(i), DW'($urandom), 0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0, 2'b00);
    do_cycle(1, 4'd4, 16'h1111, 1, 4'd6, 16'h2222, 2'b00, 4'd0, 4'd0, 2'b00);
    do_cycle(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 2'b11, 4'd0, 4'd1, 2'b11);
    do_cycle(1, 4'd0, 16'h3333, 1, 4'd1, 16'h4444, 2'b01, 4'd2, 4'd0, 2'b01);
    for (int i = 0; i < NR; i += 2)
      do_cycle(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 2'b11, AW'(i), AW'(i + 1), 2'b11);

    // random traffic over a narrow address window to force collisions
    for (int c = 0; c < 600; c++) begin
      if (c == 300) apply_reset();
      do_cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
               NP'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
               NP'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
